// File: rtl/nrisk_pkg.sv
// ---------------------------------------------------------------------------
// nrisk_pkg -- shared definitions for the instruction fetch path.
//   estado_t          : states of the fetch controller FSM
//   HALT_OP           : opcode that halts fetching (when halt detection is built)
//   NUM_LINHAS_PADRAO : default instruction-memory depth
// ---------------------------------------------------------------------------
package nrisk_pkg;

   typedef enum logic [2:0] {
      INICIO  = 3'd0,
      BUSCA   = 3'd1,
      ESPERA  = 3'd2,
      ENTREGA = 3'd3,
      PARADO  = 3'd4
   } estado_t;

   localparam logic [7:0] HALT_OP           = 8'hFF;
   localparam int         NUM_LINHAS_PADRAO = 16;

endpackage

// File: rtl/contador_pc.sv
// ---------------------------------------------------------------------------
// contador_pc -- program counter register for the fetch controller.
//   clock        in   system clock
//   reset        in   asynchronous active-high reset (pc -> 0)
//   incrementa_i in   advance pc by one, wrapping modulo NUM_LINHAS
//   carrega_i    in   load destino_i modulo NUM_LINHAS (wins over increment)
//   destino_i    in   load target
//   pc_o         out  current pc
//   pc_prox_o    out  value pc takes at the next edge
// The pc is kept 8 bits wide with the upper bits masked to zero, so the
// modulo is a single AND for every legal (power-of-two) depth.
// ---------------------------------------------------------------------------
module contador_pc
   import nrisk_pkg::*;
#(
   parameter int NUM_LINHAS = NUM_LINHAS_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       incrementa_i,
   input  logic       carrega_i,
   input  logic [7:0] destino_i,
   output logic [7:0] pc_o,
   output logic [7:0] pc_prox_o
);

   localparam logic [7:0] MASCARA = 8'(NUM_LINHAS - 1);

   logic [7:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (carrega_i)
         pc_d = destino_i & MASCARA;
      else if (incrementa_i)
         pc_d = (pc_q + 8'd1) & MASCARA;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pc_q <= 8'd0;
      else       pc_q <= pc_d;
   end

   assign pc_o      = pc_q;
   assign pc_prox_o = pc_d;

endmodule

// File: rtl/controle_busca.sv
// ---------------------------------------------------------------------------
// controle_busca -- instruction fetch controller.
// Fetches one word from instruction memory per BUSCA/ESPERA pair and holds it
// for decode in ENTREGA until accepted (valido & pronto). A redirect (desvio)
// discards whatever is in flight and restarts fetching from destino.
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   linha        out  memory address (registered, only changes entering BUSCA)
//   instrucao    in   word returned by memory (one-cycle latency)
//   instr_saida  out  instruction presented to decode
//   pc_saida     out  address instr_saida came from
//   valido       out  instr_saida/pc_saida valid
//   pronto       in   decode accepts
//   desvio       in   redirect request
//   destino      in   redirect target
//   parado       out  controller halted
// Build option: CONTROLE_BUSCA_HALT_DETECT_EN -- halt after delivering HALT_OP.
// ---------------------------------------------------------------------------
module controle_busca
   import nrisk_pkg::*;
#(
   parameter int NUM_LINHAS = NUM_LINHAS_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   output logic [7:0] linha,
   input  logic [7:0] instrucao,
   output logic [7:0] instr_saida,
   output logic [7:0] pc_saida,
   output logic       valido,
   input  logic       pronto,
   input  logic       desvio,
   input  logic [7:0] destino,
   output logic       parado
);

   estado_t    estado_q, estado_d;
   logic [7:0] linha_q, linha_d;
   logic [7:0] instr_q, pcs_q;
   logic       valido_q, valido_d;
   logic       captura;
   logic       incrementa, carrega;
   logic [7:0] pc, pc_prox;
   logic       transfere;

`ifdef CONTROLE_BUSCA_HALT_DETECT_EN
   logic       parado_q, parado_d;
`endif

   contador_pc #(.NUM_LINHAS(NUM_LINHAS)) u_pc (
      .clock        (clock),
      .reset        (reset),
      .incrementa_i (incrementa),
      .carrega_i    (carrega),
      .destino_i    (destino),
      .pc_o         (pc),
      .pc_prox_o    (pc_prox)
   );

   // valido_q is only ever set in ENTREGA, so this also implies the state
   assign transfere = valido_q & pronto;

   always_comb begin
      estado_d   = estado_q;
      valido_d   = valido_q;
      captura    = 1'b0;
      incrementa = 1'b0;
      carrega    = 1'b0;
      linha_d    = linha_q;
`ifdef CONTROLE_BUSCA_HALT_DETECT_EN
      parado_d   = parado_q;
`endif
      case (estado_q)
         INICIO: estado_d = BUSCA;   // desvio deliberately ignored here
         BUSCA: begin
            if (desvio) begin
               carrega  = 1'b1;
               estado_d = BUSCA;
            end else begin
               estado_d = ESPERA;
            end
         end
         ESPERA: begin
            if (desvio) begin
               carrega  = 1'b1;
               estado_d = BUSCA;
            end else begin
               captura  = 1'b1;
               valido_d = 1'b1;
               estado_d = ENTREGA;
            end
         end
         ENTREGA: begin
            // A redirect coinciding with a transfer still lets the transfer
            // complete; the redirect only replaces the pc increment.
            if (desvio) begin
               carrega  = 1'b1;
               valido_d = 1'b0;
               estado_d = BUSCA;
            end else if (transfere) begin
               valido_d = 1'b0;
`ifdef CONTROLE_BUSCA_HALT_DETECT_EN
               if (instr_q == HALT_OP) begin
                  parado_d = 1'b1;
                  estado_d = PARADO;   // pc left pointing at the halt word
               end else begin
                  incrementa = 1'b1;
                  estado_d   = BUSCA;
               end
`else
               incrementa = 1'b1;
               estado_d   = BUSCA;
`endif
            end
         end
         PARADO: begin
            if (desvio) begin
               carrega  = 1'b1;
               estado_d = BUSCA;
`ifdef CONTROLE_BUSCA_HALT_DETECT_EN
               parado_d = 1'b0;
`endif
            end
         end
         default: begin
            valido_d = 1'b0;
            estado_d = INICIO;
         end
      endcase
      // linha is registered, so load it on the edge that enters BUSCA to have
      // the fetch address stable for the whole BUSCA cycle.
      if (estado_d == BUSCA)
         linha_d = pc_prox;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= INICIO;
         linha_q  <= 8'd0;
         instr_q  <= 8'd0;
         pcs_q    <= 8'd0;
         valido_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         linha_q  <= linha_d;
         valido_q <= valido_d;
         if (captura) begin
            instr_q <= instrucao;
            pcs_q   <= pc;
         end
      end
   end

`ifdef CONTROLE_BUSCA_HALT_DETECT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) parado_q <= 1'b0;
      else       parado_q <= parado_d;
   end
   assign parado = parado_q;
`else
   assign parado = 1'b0;
`endif

   assign linha       = linha_q;
   assign instr_saida = instr_q;
   assign pc_saida    = pcs_q;
   assign valido      = valido_q;

endmodule

// File: tb/tb_controle_busca.sv
module tb_controle_busca;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] linha, instrucao, instr_saida, pc_saida, destino;
   logic       valido, pronto, desvio, parado;

   logic [7:0] mem [0:255];
   assign instrucao = mem[linha];

   typedef struct {
      logic [7:0] pc;
      logic [7:0] instr;
      int         cyc;     // -1: cycle not checked
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   controle_busca #(.NUM_LINHAS(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .linha       (linha),
      .instrucao   (instrucao),
      .instr_saida (instr_saida),
      .pc_saida    (pc_saida),
      .valido      (valido),
      .pronto      (pronto),
      .desvio      (desvio),
      .destino     (destino),
      .parado      (parado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] p, input logic [7:0] i, input int c);
      exp_t e;
      e.pc = p; e.instr = i; e.cyc = c;
      sb.push_back(e);
   endtask

   // Called between edges: the values seen now are what the next posedge samples.
   task automatic tick();
      exp_t e;
      if (!reset && valido === 1'b1 && pronto === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_xfer", {16'd0, pc_saida, instr_saida}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("xfer_pc", {24'd0, pc_saida}, {24'd0, e.pc});
            chk("xfer_instr", {24'd0, instr_saida}, {24'd0, e.instr});
            if (e.cyc >= 0) chk("xfer_cyc", cyc, e.cyc);
         end
      end
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() > 0; i++) tick();
      chk("sb_drain", sb.size(), 0);
   endtask

   task automatic wait_valido(input int budget);
      for (int i = 0; i < budget && valido !== 1'b1; i++) tick();
      chk("wait_valido", {31'd0, valido}, 1);
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1'b0;
      cyc   = 1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(8'h50 + i);
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      pronto = 1'b1; desvio = 1'b0; destino = 8'h00;

      // reset state
      repeat (2) @(negedge clock);
      chk("rst_linha", {24'd0, linha}, 0);
      chk("rst_instr", {24'd0, instr_saida}, 0);
      chk("rst_pcs", {24'd0, pc_saida}, 0);
      chk("rst_valido", {31'd0, valido}, 0);
      chk("rst_parado", {31'd0, parado}, 0);

      // back-to-back fetch, pronto held high
      release_reset();
      push(8'd0, 8'h11, 4); push(8'd1, 8'h22, 7);
      push(8'd2, 8'h33, 10); push(8'd3, 8'h44, 13);
      tick();
      chk("c2_linha", {24'd0, linha}, 0);
      tick();
      chk("c3_valido", {31'd0, valido}, 0);
      tick();
      chk("c4_valido", {31'd0, valido}, 1);
      drain(40);

      // stall in ENTREGA for 5 cycles
      pronto = 1'b0;
      wait_valido(10);
      for (int k = 0; k < 5; k++) begin
         chk("stall_valido", {31'd0, valido}, 1);
         chk("stall_pcs", {24'd0, pc_saida}, 4);
         chk("stall_instr", {24'd0, instr_saida}, {24'd0, mem[4]});
         chk("stall_linha", {24'd0, linha}, 4);
         tick();
      end
      push(8'd4, mem[4], cyc);
      pronto = 1'b1;
      drain(10);

      // run through line 15 and wrap
      for (int i = 5; i < 16; i++) push(8'(i), mem[i], -1);
      drain(60);
      chk("wrap_linha", {24'd0, linha}, 0);
      chk("wrap_valido", {31'd0, valido}, 0);

      // redirect in BUSCA, target beyond depth
      desvio = 1'b1; destino = 8'h23;
      push(8'd3, 8'h44, -1);
      tick();
      desvio = 1'b0;
      chk("desvio_mod_linha", {24'd0, linha}, 3);
      drain(10);

      // redirect during ESPERA discards line 4
      tick();
      desvio = 1'b1; destino = 8'h09;
      push(8'd9, mem[9], -1);
      tick();
      desvio = 1'b0;
      chk("espera_desvio_valido", {31'd0, valido}, 0);
      drain(10);

      // redirect in ENTREGA without transfer discards the held word
      pronto = 1'b0;
      wait_valido(10);
      desvio = 1'b1; destino = 8'h01;
      push(8'd1, 8'h22, -1);
      tick();
      desvio = 1'b0;
      chk("entrega_desvio_valido", {31'd0, valido}, 0);
      pronto = 1'b1;
      drain(10);

      // redirect together with a transfer: transfer completes, then destino
      pronto = 1'b0;
      wait_valido(10);
      push(8'd2, 8'h33, -1); push(8'd12, mem[12], -1);
      pronto = 1'b1; desvio = 1'b1; destino = 8'h0C;
      tick();
      desvio = 1'b0;
      drain(10);

      // halt opcode
      mem[2] = 8'hFF;
      desvio = 1'b1; destino = 8'h01;
      push(8'd1, 8'h22, -1); push(8'd2, 8'hFF, -1);
      tick();
      desvio = 1'b0;
      drain(20);
`ifdef CONTROLE_BUSCA_HALT_DETECT_EN
      for (int k = 0; k < 4; k++) tick();
      chk("halt_parado", {31'd0, parado}, 1);
      chk("halt_valido", {31'd0, valido}, 0);
      chk("halt_linha", {24'd0, linha}, 2);
      desvio = 1'b1; destino = 8'h00;
      push(8'd0, 8'h11, -1);
      tick();
      desvio = 1'b0;
      chk("unhalt_parado", {31'd0, parado}, 0);
      chk("unhalt_linha", {24'd0, linha}, 0);
      drain(10);
`else
      push(8'd3, 8'h44, -1);
      drain(10);
      chk("nohalt_parado", {31'd0, parado}, 0);
`endif

      // asynchronous reset while a word is held
      pronto = 1'b0;
      wait_valido(10);
      #2 reset = 1'b1;
      #1;
      chk("arst_valido", {31'd0, valido}, 0);
      chk("arst_linha", {24'd0, linha}, 0);
      chk("arst_pcs", {24'd0, pc_saida}, 0);
      mem[2] = 8'h33;
      pronto = 1'b1;
      @(negedge clock);
      release_reset();
      push(8'd0, 8'h11, 4); push(8'd1, 8'h22, 7);
      drain(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/controle_busca.md
CONTROLE_BUSCA -- requirements
Module: controle_busca

Interface
REQ-001 Parameter NUM_LINHAS, default 16: number of instruction-memory lines; legal values are powers of two, 2 to 256.
REQ-002 clock  in  1  system clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 linha  out  8  address to instruction memory; registered.
REQ-005 instrucao  in  8  instruction word returned by memory.
REQ-006 instr_saida  out  8  fetched instruction presented to decode.
REQ-007 pc_saida  out  8  address from which instr_saida was fetched.
REQ-008 valido  out  1  instr_saida/pc_saida valid.
REQ-009 pronto  in  1  decode accepts; a transfer occurs on a cycle with valido=1 and pronto=1.
REQ-010 desvio  in  1  redirect request, single-cycle qualified.
REQ-011 destino  in  8  redirect target, sampled with desvio.
REQ-012 parado  out  1  controller halted.

Function
REQ-013 FSM states: INICIO, BUSCA, ESPERA, ENTREGA, PARADO.
REQ-014 INICIO: one cycle after reset release, then BUSCA.
REQ-015 BUSCA: linha=pc for the whole cycle; next state is ESPERA.
REQ-016 ESPERA: memory latency cycle; at its closing edge instr_saida<=instrucao, pc_saida<=pc, and the next state is ENTREGA.
REQ-017 ENTREGA: valido=1; instr_saida and pc_saida are held stable until a transfer.
REQ-018 On a transfer: pc<=(pc+1) mod NUM_LINHAS, valido deasserts next cycle, and the next state is BUSCA.
REQ-019 Without stalls, throughput is one instruction per 3 cycles; first valido is asserted on cycle 4 after reset release.
REQ-020 Wrap-around: pc=NUM_LINHAS-1 followed by a transfer gives pc=0.
REQ-021 desvio=1 in BUSCA, ESPERA or ENTREGA: pc<=destino mod NUM_LINHAS, any in-flight or held instruction is discarded (valido=0 next cycle), and the next state is BUSCA.
REQ-022 desvio and a transfer in the same cycle: the transfer completes, and the next fetch is from destino.
REQ-023 desvio in PARADO: parado clears and the controller fetches from destino.
REQ-024 desvio in INICIO is ignored.
REQ-025 linha holds its last value outside BUSCA.
REQ-026 pronto is ignored when valido=0.

Reset
REQ-027 Asynchronous assertion forces: state=INICIO, pc=0, linha=0, instr_saida=0, pc_saida=0, valido=0, parado=0.
REQ-028 Reset mid-operation abandons any pending instruction; no transfer is reported after reset asserts.

Configuration
REQ-029 Macro CONTROLE_BUSCA_HALT_DETECT_EN, when defined: a captured instruction equal to 8'hFF is delivered normally; after its transfer the state becomes PARADO, parado=1, pc is unchanged and no further fetches occur.
REQ-030 Without CONTROLE_BUSCA_HALT_DETECT_EN: 8'hFF is an ordinary instruction, the PARADO state is unreachable, and parado is constant 0.

Structure
REQ-031 The shared package nrisk_pkg holds the FSM state enum, the HALT opcode constant (8'hFF) and the NUM_LINHAS default.
REQ-032 Sub-module contador_pc holds the PC register with increment, modulo wrap and load of destino.

Verification
REQ-033 Memory lines 0..3 = 8'h11,22,33,44; pronto=1 -> transfers at cycles 4,7,10,13 with (pc_saida,instr_saida) = (0,11),(1,22),(2,33),(3,44).
REQ-034 pronto=0 for 5 cycles in ENTREGA -> valido stays 1, outputs stable, linha unchanged; the transfer occurs on the first cycle pronto=1.
REQ-035 NUM_LINHAS=16, run to line 15 -> the next fetch has linha=0; destino=8'h23 -> pc=3.
REQ-036 desvio=1, destino=8'h09 during ESPERA -> valido is never asserted for the in-flight word; the next transfer has pc_saida=9.
REQ-037 With macro defined, line 2 = 8'hFF -> transfer of FF, then parado=1 and linha frozen; desvio to 0 -> parado=0 and line 0 is refetched. Without macro: FF is transferred and the fetch of line 3 follows.
REQ-038 Reset asserted in ENTREGA -> valido=0 and linha=0 immediately; normal sequence restarts from line 0.
